// File: rtl/argmax_pkg.sv
// Shared types and sizes for the argmax stream stage.
// Build option: ARGMAX_OBUF_EN overlaps accumulation with a pending result.
package argmax_pkg;
    localparam int WIDTH = 16;
    localparam int N = 10;
    localparam int LOGN = $clog2(N);

    typedef enum logic [0:0] {ACC, HOLD} argmax_state_t;
    typedef logic signed [WIDTH-1:0] score_t;
    typedef logic [LOGN-1:0] idx_t;

    localparam idx_t LAST = idx_t'(N - 1);
endpackage

// File: rtl/argmax_stream_10_16_if.sv
// Score-in / result-out handshake bundle for argmax_stream_10_16.
// Build option: ARGMAX_OBUF_EN (affects only the DUT behaviour).
interface argmax_stream_10_16_if;
    import argmax_pkg::*;

    logic input_valid;
    logic input_ready;
    score_t input_data;
    logic output_valid;
    logic output_ready;
    idx_t output_data;
    score_t output_max;

    modport slave (
        input input_valid,
        input input_data,
        output input_ready,
        output output_valid,
        input output_ready,
        output output_data,
        output output_max
    );

    modport master (
        output input_valid,
        output input_data,
        input input_ready,
        input output_valid,
        output output_ready,
        input output_data,
        input output_max
    );
endinterface

// File: rtl/argmax_cmp.sv
// Signed running-max select; strict compare so the lowest index wins ties.
// Build option: ARGMAX_OBUF_EN (not used here).
module argmax_cmp
    import argmax_pkg::*;
(
    input score_t cur_max,
    input idx_t cur_idx,
    input score_t new_score,
    input idx_t new_idx,
    output score_t nxt_max,
    output idx_t nxt_idx
);
    logic take;

    assign take = new_score > cur_max;
    assign nxt_max = take ? new_score : cur_max;
    assign nxt_idx = take ? new_idx : cur_idx;
endmodule

// File: rtl/argmax_stream_10_16.sv
// Argmax over each 10-score vector with a one-deep result register.
// Build option: ARGMAX_OBUF_EN keeps input_ready high while a result waits.
module argmax_stream_10_16
    import argmax_pkg::*;
(
    input logic clk,
    input logic reset_n,
    argmax_stream_10_16_if.slave bus
);
    argmax_state_t state;
    argmax_state_t state_nxt;
    idx_t cnt;
    score_t run_max;
    idx_t run_idx;
    score_t nxt_max;
    idx_t nxt_idx;
    logic ready;
    logic accept;
    logic last;
    logic drain;

    argmax_cmp u_cmp (
        .cur_max(run_max),
        .cur_idx(run_idx),
        .new_score(bus.input_data),
        .new_idx(cnt),
        .nxt_max(nxt_max),
        .nxt_idx(nxt_idx)
    );

    assign last = cnt == LAST;
    assign drain = bus.output_valid && bus.output_ready;
    assign bus.input_ready = ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state <= ACC;
        else state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        ready = 1'b0;
        unique case (state)
            ACC: ready = 1'b1;
            HOLD: begin
`ifdef ARGMAX_OBUF_EN
                // only the closing beat must wait for the result slot
                ready = !last || bus.output_ready;
`else
                ready = 1'b0;
`endif
            end
            default: ready = 1'b0;
        endcase
        ready = ready && reset_n;
        accept = bus.input_valid && ready;
        if (accept && last) state_nxt = HOLD;
        else if (drain) state_nxt = ACC;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
            run_max <= '0;
            run_idx <= '0;
            bus.output_valid <= 1'b0;
            bus.output_data <= '0;
            bus.output_max <= '0;
        end else begin
            if (accept) begin
                if (cnt == '0) begin
                    run_max <= bus.input_data;
                    run_idx <= '0;
                end else begin
                    run_max <= nxt_max;
                    run_idx <= nxt_idx;
                end
                cnt <= last ? '0 : cnt + 1'b1;
            end
            if (accept && last) begin
                bus.output_valid <= 1'b1;
                bus.output_data <= nxt_idx;
                bus.output_max <= nxt_max;
            end else if (drain) begin
                bus.output_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_argmax_stream_10_16.sv
// Self-checking bench for argmax_stream_10_16 (table, random, corner cases).
// Build option: ARGMAX_OBUF_EN selects the overlapped-backpressure expectations.
module tb_argmax_stream_10_16;
    import argmax_pkg::*;

    typedef score_t vec_t [N];
    typedef struct {
        string nm;
        vec_t v;
        int idx;
        int mx;
    } vrec_t;

    logic clk = 1'b0;
    logic reset_n;
    int errs = 0;
    int checks = 0;

    argmax_stream_10_16_if bus();

    argmax_stream_10_16 dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic score_t s(input int x);
        return score_t'(x);
    endfunction

    // Reference: first position holding the largest value.
    function automatic void ref_argmax(
        input vec_t v, output int idx, output int mx);
        int best;
        best = int'(v[0]);
        idx = 0;
        foreach (v[k]) begin
            if (int'(v[k]) > best) begin
                best = int'(v[k]);
                idx = k;
            end
        end
        mx = best;
    endfunction

    task automatic chk(input string nm,
        input logic signed [31:0] got,
        input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d", nm, got, exp);
        end
    endtask

    task automatic send_vec(input vec_t v, input bit gaps,
        input int nb);
        bit acc;
        @(posedge clk); #1;
        for (int k = 0; k < nb; k++) begin
            if (gaps) begin
                bus.input_valid = 1'b0;
                bus.input_data = s(int'($urandom));
                @(posedge clk); #1;
            end
            bus.input_valid = 1'b1;
            bus.input_data = v[k];
            acc = 1'b0;
            for (int w = 0; w < 40 && !acc; w++) begin
                @(negedge clk);
                acc = bus.input_ready;
                @(posedge clk); #1;
            end
            if (!acc) chk("beat_timeout", 0, 1);
        end
        bus.input_valid = 1'b0;
    endtask

    task automatic get_result(input string nm,
        input int ei, input int em);
        int w;
        w = 0;
        @(negedge clk);
        while (!bus.output_valid && w < 40) begin
            w++;
            @(negedge clk);
        end
        chk({nm, "_valid"}, bus.output_valid, 1);
        chk({nm, "_latency"}, w, 0);
        chk({nm, "_idx"}, bus.output_data, ei);
        chk({nm, "_max"}, bus.output_max, em);
        @(posedge clk); #1;
    endtask

    task automatic rand_vec(output vec_t v);
        int mode;
        int pick;
        mode = int'($urandom_range(0, 2));
        foreach (v[k]) begin
            pick = int'($urandom_range(0, 3));
            case (mode)
                0: v[k] = s(int'($urandom));
                1: v[k] = s(pick);
                default: v[k] = (pick == 0) ? s(-32768) :
                    (pick == 1) ? s(32767) : s(pick - 3);
            endcase
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vrec_t tbl[6];
        vec_t v;
        vec_t v5;
        int ei;
        int em;
        int hd;
        int hm;
        int w;

        foreach (tbl[i]) foreach (tbl[i].v[k]) tbl[i].v[k] = s(0);
        tbl[0].nm = "t1";
        tbl[0].v[0] = s(5);
        tbl[0].v[1] = s(-3);
        tbl[0].v[2] = s(7);
        tbl[0].v[3] = s(7);
        tbl[0].idx = 2;
        tbl[0].mx = 7;
        tbl[1].nm = "t2_ramp";
        for (int k = 0; k < N; k++) tbl[1].v[k] = s(-100 + k);
        tbl[1].idx = 9;
        tbl[1].mx = -91;
        tbl[2].nm = "t3_max_last";
        for (int k = 0; k < N; k++) tbl[2].v[k] = s(-32768);
        tbl[2].v[9] = s(32767);
        tbl[2].idx = 9;
        tbl[2].mx = 32767;
        tbl[3].nm = "t3_max_first";
        for (int k = 0; k < N; k++) tbl[3].v[k] = s(-32768);
        tbl[3].v[0] = s(32767);
        tbl[3].idx = 0;
        tbl[3].mx = 32767;
        tbl[4].nm = "all_equal";
        for (int k = 0; k < N; k++) tbl[4].v[k] = s(-5);
        tbl[4].idx = 0;
        tbl[4].mx = -5;
        tbl[5].nm = "all_zero";
        tbl[5].idx = 0;
        tbl[5].mx = 0;

        reset_n = 1'b1;
        bus.input_valid = 1'b0;
        bus.input_data = '0;
        bus.output_ready = 1'b1;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_valid", bus.output_valid, 0);
        chk("rst_idx", bus.output_data, 0);
        chk("rst_max", bus.output_max, 0);
        chk("rst_ready", bus.input_ready, 0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        #1 chk("rel_ready", bus.input_ready, 1);

        foreach (tbl[i]) begin
            send_vec(tbl[i].v, 1'b0, N);
            get_result(tbl[i].nm, tbl[i].idx, tbl[i].mx);
        end

        for (int r = 0; r < 30; r++) begin
            rand_vec(v);
            ref_argmax(v, ei, em);
            send_vec(v, $urandom_range(0, 1) == 1, N);
            get_result("rand", ei, em);
        end

        // Backpressure: result must hold while output_ready is low.
        bus.output_ready = 1'b0;
        for (int k = 0; k < N; k++) v[k] = s(k * 3 - 10);
        v[4] = s(1000);
        send_vec(v, 1'b0, N);
        w = 0;
        @(negedge clk);
        while (!bus.output_valid && w < 40) begin
            w++;
            @(negedge clk);
        end
        chk("t4_idx", bus.output_data, 4);
        chk("t4_max", bus.output_max, 1000);
        hd = int'(bus.output_data);
        hm = int'(bus.output_max);
        rand_vec(v5);
        ref_argmax(v5, ei, em);
`ifdef ARGMAX_OBUF_EN
        for (int c = 0; c < N; c++) begin
            @(posedge clk); #1;
            bus.input_valid = 1'b1;
            bus.input_data = v5[c];
            @(negedge clk);
            chk("t4_hold_valid", bus.output_valid, 1);
            chk("t4_hold_idx", bus.output_data, hd);
            chk("t4_hold_max", bus.output_max, hm);
            chk("t4_in_ready", bus.input_ready,
                (c < N - 1) ? 1 : 0);
        end
        @(posedge clk); #1;
        bus.output_ready = 1'b1;
        @(negedge clk);
        chk("t4_stall_idx", bus.output_data, hd);
        chk("t4_last_ready", bus.input_ready, 1);
        @(posedge clk); #1;
        bus.input_valid = 1'b0;
        @(negedge clk);
        chk("t4_next_valid", bus.output_valid, 1);
        chk("t4_next_idx", bus.output_data, ei);
        chk("t4_next_max", bus.output_max, em);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_drained", bus.output_valid, 0);
`else
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("t4_hold_valid", bus.output_valid, 1);
            chk("t4_hold_idx", bus.output_data, hd);
            chk("t4_hold_max", bus.output_max, hm);
            chk("t4_in_ready", bus.input_ready, 0);
        end
        @(posedge clk); #1;
        bus.output_ready = 1'b1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_drained", bus.output_valid, 0);
        chk("t4_ready_back", bus.input_ready, 1);
        send_vec(v5, 1'b0, N);
        get_result("t4_next", ei, em);
`endif

        // Mid-vector reset discards the partial vector.
        for (int k = 0; k < N; k++) v[k] = s(k + 1);
        send_vec(v, 1'b0, 4);
        reset_n = 1'b0;
        #1;
        chk("t5_rst_valid", bus.output_valid, 0);
        chk("t5_rst_idx", bus.output_data, 0);
        chk("t5_rst_max", bus.output_max, 0);
        chk("t5_rst_ready", bus.input_ready, 0);
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        for (int k = 0; k < N; k++) v[k] = s(0);
        v[6] = s(8);
        send_vec(v, 1'b0, N);
        get_result("t5", 6, 8);

        send_vec(tbl[0].v, 1'b1, N);
        get_result("t6_gaps", 2, 7);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
